// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with valid, stall, flush, gated flags and perf counters
module ex_mem_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4,
    parameter int MEM_W  = 2,
    parameter int WB_W   = 3,
    parameter int FLAG_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [RD_W-1:0]   rd_addr_in,
    input  logic [MEM_W-1:0]  mem_signals_in,
    input  logic [WB_W-1:0]   wb_signals_in,
    input  logic [FLAG_W-1:0] flags_ctl,
    input  logic [FLAG_W-1:0] flags_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] data_out,
    output logic [RD_W-1:0]   rd_addr_out,
    output logic [MEM_W-1:0]  mem_signals_out,
    output logic [WB_W-1:0]   wb_signals_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    logic load, take, bubble, held;
    logic [FLAG_W-1:0] flag_we;
    assign load    = !stall && !flush;
    assign take    = load && valid_in;
    assign bubble  = flush || (load && !valid_in);
    assign held    = stall && !flush;
    assign flag_we = take ? flags_ctl : '0;
    // datapath fields follow the inputs whenever not held; control is zeroed for bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out       <= 1'b0;
            pc_out          <= '0;
            alu_out         <= '0;
            data_out        <= '0;
            rd_addr_out     <= '0;
            mem_signals_out <= '0;
            wb_signals_out  <= '0;
            flags_out       <= '0;
        end else begin
            if (!held) begin
                pc_out          <= pc_in;
                alu_out         <= alu_in;
                data_out        <= data_in;
                rd_addr_out     <= rd_addr_in;
                valid_out       <= take;
                mem_signals_out <= take ? mem_signals_in : '0;
                wb_signals_out  <= take ? wb_signals_in : '0;
            end
            flags_out <= (flags_out & ~flag_we) | (flags_in & flag_we);
        end
    end
    // saturating bubble and stall counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + cnt_one;
            if (held && stall_cnt != '1) stall_cnt <= stall_cnt + cnt_one;
        end
    end
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed bench with a behavioural model checked every cycle
module tb_ex_mem_pipe_reg;
    localparam int CW = 4;
    localparam int CMAX = 15;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
    logic [15:0] pc_in = '0, alu_in = '0, data_in = '0;
    logic [3:0] rd_addr_in = '0;
    logic [1:0] mem_signals_in = '0;
    logic [2:0] wb_signals_in = '0, flags_ctl = '0, flags_in = '0;
    logic valid_out;
    logic [15:0] pc_out, alu_out, data_out;
    logic [3:0] rd_addr_out;
    logic [1:0] mem_signals_out;
    logic [2:0] wb_signals_out, flags_out;
    logic [CW-1:0] bubble_cnt, stall_cnt;
    int errors = 0, checks = 0;
    logic m_valid;
    logic [15:0] m_pc, m_alu, m_data;
    logic [3:0] m_rd;
    logic [1:0] m_mem;
    logic [2:0] m_wb, m_flags;
    int m_bub, m_stl;

    ex_mem_pipe_reg #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .alu_in(alu_in), .data_in(data_in), .rd_addr_in(rd_addr_in),
        .mem_signals_in(mem_signals_in), .wb_signals_in(wb_signals_in),
        .flags_ctl(flags_ctl), .flags_in(flags_in), .valid_out(valid_out),
        .pc_out(pc_out), .alu_out(alu_out), .data_out(data_out), .rd_addr_out(rd_addr_out),
        .mem_signals_out(mem_signals_out), .wb_signals_out(wb_signals_out),
        .flags_out(flags_out), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: what the stage must hold after each edge, from the behavioural rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_pc = 0; m_alu = 0; m_data = 0; m_rd = 0;
            m_mem = 0; m_wb = 0; m_flags = 0; m_bub = 0; m_stl = 0;
        end else if (flush) begin
            m_valid = 0; m_mem = 0; m_wb = 0;
            m_pc = pc_in; m_alu = alu_in; m_data = data_in; m_rd = rd_addr_in;
            m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
        end else if (stall) begin
            m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
        end else begin
            m_valid = valid_in;
            m_pc = pc_in; m_alu = alu_in; m_data = data_in; m_rd = rd_addr_in;
            m_mem = valid_in ? mem_signals_in : 2'b0;
            m_wb = valid_in ? wb_signals_in : 3'b0;
            for (int i = 0; i < 3; i++)
                if (valid_in && flags_ctl[i]) m_flags[i] = flags_in[i];
            if (!valid_in) m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", valid_out, m_valid);
            check("pc", pc_out, m_pc);
            check("alu", alu_out, m_alu);
            check("data", data_out, m_data);
            check("rd", rd_addr_out, m_rd);
            check("mem", mem_signals_out, m_mem);
            check("wb", wb_signals_out, m_wb);
            check("flags", flags_out, m_flags);
            check("bubble_cnt", bubble_cnt, m_bub[CW-1:0]);
            check("stall_cnt", stall_cnt, m_stl[CW-1:0]);
            if (!valid_out) check("ctl_zero_when_invalid", {mem_signals_out, wb_signals_out}, 5'b0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ld(input logic v, input logic [15:0] alu, input logic [2:0] ctl, input logic [2:0] fl);
        stall = 0; flush = 0; valid_in = v; alu_in = alu; flags_ctl = ctl; flags_in = fl;
        cyc();
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", valid_out, 1'b0);
        check("rst_pc", pc_out, 16'h0);
        rst = 0;
        // reset in the middle of operation acts before any edge
        valid_in = 1; pc_in = 16'h1234; flags_ctl = 3'b111; flags_in = 3'b101;
        cyc();
        check("pre_rst_pc", pc_out, 16'h1234);
        check("pre_rst_flags", flags_out, 3'b101);
        #2 rst = 1;
        #1;
        check("async_rst_pc", pc_out, 16'h0);
        check("async_rst_flags", flags_out, 3'b0);
        check("async_rst_valid", valid_out, 1'b0);
        check("async_rst_cnt", {bubble_cnt, stall_cnt}, 8'h0);
        rst = 0;
        @(negedge clk);
        // plain load
        rd_addr_in = 4'hA; wb_signals_in = 3'b101; mem_signals_in = 2'b10; pc_in = 16'h0040;
        ld(1, 16'hBEEF, 3'b000, 3'b000);
        check("load_alu", alu_out, 16'hBEEF);
        check("load_rd", rd_addr_out, 4'hA);
        check("load_wb", wb_signals_out, 3'b101);
        check("load_mem", mem_signals_out, 2'b10);
        check("load_valid", valid_out, 1'b1);
        ld(1, 16'h1111, 3'b111, 3'b001);
        check("flags_set", flags_out, 3'b001);
        // stall three cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            stall = 1; alu_in = 16'h2000 + 16'(i); pc_in = 16'h3000 + 16'(i);
            flags_ctl = 3'b111; flags_in = 3'b110; wb_signals_in = 3'(i);
            cyc();
        end
        check("stall_alu", alu_out, 16'h1111);
        check("stall_flags", flags_out, 3'b001);
        check("stall_cnt3", stall_cnt, 4'd3);
        check("stall_bub", bubble_cnt, 4'd0);
        // flush beats stall
        stall = 1; flush = 1; valid_in = 1; wb_signals_in = 3'b111; flags_ctl = 3'b111; flags_in = 3'b010;
        cyc();
        check("flush_valid", valid_out, 1'b0);
        check("flush_wb", wb_signals_out, 3'b0);
        check("flush_mem", mem_signals_out, 2'b0);
        check("flush_flags", flags_out, 3'b001);
        check("flush_bub", bubble_cnt, 4'd1);
        check("flush_stall", stall_cnt, 4'd3);
        // partial flag write, then with valid_in low
        wb_signals_in = 3'b011; mem_signals_in = 2'b01;
        ld(1, 16'h0, 3'b111, 3'b000);
        ld(1, 16'h5, 3'b010, 3'b111);
        check("partial_flags", flags_out, 3'b010);
        ld(0, 16'h6, 3'b010, 3'b000);
        check("invalid_flags", flags_out, 3'b010);
        check("invalid_wb", wb_signals_out, 3'b0);
        check("invalid_mem", mem_signals_out, 2'b0);
        check("invalid_bub", bubble_cnt, 4'd2);
        // mixed directed traffic under the model
        for (int i = 0; i < 24; i++) begin
            stall = (i % 5 == 2); flush = (i % 7 == 3); valid_in = (i % 3 != 0);
            pc_in = 16'(i * 4); alu_in = 16'(i * 16'h0101); data_in = 16'(16'hA5A5 ^ i);
            rd_addr_in = 4'(i); mem_signals_in = 2'(i); wb_signals_in = 3'(i + 1);
            flags_ctl = 3'(i * 3); flags_in = 3'(i * 5);
            cyc();
        end
        // saturation of both counters
        stall = 1; flush = 0;
        for (int i = 0; i < 20; i++) cyc();
        check("stall_sat", stall_cnt, 4'd15);
        stall = 0; valid_in = 0;
        for (int i = 0; i < 20; i++) cyc();
        check("bubble_sat", bubble_cnt, 4'd15);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
